// File: rtl/little_mem_responder.sv
// Target end of the little CPU memory bus: one request at a time, WAIT_CYCLES wait states,
// one-cycle synchronous RAM access, then a response that is held until the initiator takes it.
`timescale 1ns/1ps
module little_mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [ADDR_BITS-1:0] i_req_addr,
  input  logic [DATA_BITS-1:0] i_req_wdata,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DATA_BITS-1:0] o_rsp_rdata,
  output logic                 o_rsp_err,
  output logic                 o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t                 state;
  logic [3:0]             cnt;
  logic                   we_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [DATA_BITS-1:0]   wdata_q;
  logic [DATA_BITS-1:0]   mem [DEPTH];
  logic                   in_range;

  // One extra bit so DEPTH == 2**ADDR_BITS compares correctly.
  assign in_range    = ({1'b0, addr_q} < (ADDR_BITS+1)'(DEPTH));
  assign o_req_ready = (state == S_IDLE) && !i_rst;
  assign o_busy      = (state != S_IDLE);

  // RAM has no reset; reset still wins over a write in the ACCESS cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == S_ACCESS && we_q && in_range)
      mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            we_q    <= i_req_we;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            cnt     <= WAIT_LD;
            state   <= (WAIT_LD != 4'd0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1)
            state <= S_ACCESS;
        end
        S_ACCESS: begin
          o_rsp_rdata <= (in_range && !we_q) ? mem[addr_q] : '0;
          o_rsp_err   <= !in_range;
          o_rsp_valid <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_little_mem_responder.sv
// Directed bench: table of request vectors plus hand-written sequences for backpressure,
// reset abort, ignored requests and zero-wait throughput.
`timescale 1ns/1ps
module tb_little_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata, rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
  logic [7:0]  z_req_addr;
  logic [15:0] z_req_wdata, z_rsp_rdata;

  little_mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .DEPTH(200), .WAIT_CYCLES(2)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_busy(busy)
  );

  little_mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(z_req_valid), .o_req_ready(z_req_ready), .i_req_we(z_req_we),
    .i_req_addr(z_req_addr), .i_req_wdata(z_req_wdata),
    .o_rsp_valid(z_rsp_valid), .i_rsp_ready(z_rsp_ready), .o_rsp_rdata(z_rsp_rdata),
    .o_rsp_err(z_rsp_err), .o_busy(z_busy)
  );

  int nvec = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Preload pattern; address 5 deliberately holds zero.
  function automatic logic [15:0] pat(input int a);
    return (a == 5) ? 16'h0000 : 16'(16'h1000 + a * 7);
  endfunction

  // Edges counts the accept edge as edge 1; returns as soon as the response is visible,
  // and also completes the handshake when rsp_ready is high.
  task automatic txn(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                     output logic [15:0] rd, output logic er, output int edges);
    int guard;
    rd = '0; er = 1'b0; edges = 0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!req_ready) begin check("accept_timeout", 0, 1); req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd;
    edges = 1;
    while (!rsp_valid && edges < 50) begin @(posedge clk); #1; edges++; end
    if (!rsp_valid) begin check("rsp_timeout", 0, 1); return; end
    rd = rsp_rdata; er = rsp_err;
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          edges, guard, nresp, first_vld;
    int          acc[$];

    vecs[0]  = '{1'b1, 8'h10, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 8'h10, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2]  = '{1'b0, 8'hC8, 16'h0000, 16'h0000, 1'b1};
    vecs[3]  = '{1'b1, 8'hFF, 16'h1234, 16'h0000, 1'b1};
    vecs[4]  = '{1'b0, 8'hC7, 16'h0000, 16'h1571, 1'b0};
    vecs[5]  = '{1'b1, 8'hC7, 16'h5A5A, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 8'hC7, 16'h0000, 16'h5A5A, 1'b0};
    vecs[7]  = '{1'b0, 8'h05, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 16'h0000, 16'h1000, 1'b0};
    vecs[9]  = '{1'b1, 8'hC8, 16'h7777, 16'h0000, 1'b1};
    vecs[10] = '{1'b0, 8'h80, 16'h0000, 16'h1380, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_z_rsp_valid", z_rsp_valid, 0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1);

    for (int a = 0; a < 200; a++) begin
      txn(1'b1, 8'(a), pat(a), rd, er, edges);
      check($sformatf("preload_err_%0d", a), er, 0);
    end

    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, edges);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d_edges", i), edges, 4);
    end

    // Out-of-range writes must not alias into the array
    for (int a = 0; a < 200; a++) begin
      txn(1'b0, 8'(a), 16'h0, rd, er, edges);
      check($sformatf("scan_%0d", a), rd,
            (a == 8'h10) ? 16'hBEEF : (a == 8'hC7) ? 16'h5A5A : pat(a));
    end

    // Backpressure
    rsp_ready = 1'b0;
    txn(1'b0, 8'h10, 16'h0, rd, er, edges);
    check("bp_edges", edges, 4);
    check("bp_first_rdata", rd, 16'hBEEF);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_%0d", k), rsp_valid, 1);
      check($sformatf("bp_rdata_%0d", k), rsp_rdata, 16'hBEEF);
      check($sformatf("bp_req_ready_%0d", k), req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_after", rsp_valid, 0);
    check("bp_busy_after", busy, 0);
    check("bp_req_ready_after", req_ready, 1);

    // Reset during the wait states of a write
    @(negedge clk);
    req_we = 1'b1; req_addr = 8'h05; req_wdata = 16'hAAAA; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    check("rstw_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstw_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstw_rsp_valid", rsp_valid, 0);
    check("rstw_rdata", rsp_rdata, 0);
    check("rstw_err", rsp_err, 0);
    check("rstw_busy_after", busy, 0);
    check("rstw_req_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    check("rstw_req_ready_rel", req_ready, 1);
    txn(1'b0, 8'h05, 16'h0, rd, er, edges);
    check("rstw_readback", rd, 16'h0000);

    // Request pulsed during WAIT of another transaction is dropped
    @(negedge clk);
    req_we = 1'b0; req_addr = 8'h10; req_wdata = 16'h0; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 8'h22; req_wdata = 16'hDEAD;
    check("ign_req_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 2;
    while (!rsp_valid && edges < 50) begin @(posedge clk); #1; edges++; end
    check("ign_edges", edges, 4);
    check("ign_rdata", rsp_rdata, 16'hBEEF);
    @(posedge clk); #1;
    nresp = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) nresp++;
    end
    check("ign_extra_activity", nresp, 0);
    txn(1'b0, 8'h22, 16'h0, rd, er, edges);
    check("ign_no_write", rd, 16'h10EE);

    // Zero wait states, request held high
    z_req_valid = 1'b1;
    first_vld = -1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (z_req_ready) acc.push_back(c);
      @(posedge clk); #1;
      if (z_rsp_valid && first_vld < 0) first_vld = c;
    end
    z_req_valid = 1'b0;
    check("zw_accepts", acc.size(), 5);
    for (int i = 0; i + 1 < acc.size(); i++)
      check($sformatf("zw_spacing_%0d", i), acc[i+1] - acc[i], 3);
    if (acc.size() > 0)
      check("zw_latency", first_vld - acc[0] + 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
